// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM states, stat width and address-split helpers for set_assoc_cache
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL,
        RESPOND
    } state_e;

    localparam int STAT_W = 32;

    // Helpers work on a 64-bit view so one definition serves every ADDR_W up to 64.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int off_w);
        return addr & ((64'd1 << off_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - victim way choice: lowest invalid way, else round-robin pointer
module cache_victim_sel #(
    parameter int WAYS  = 8,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] victim,
    output logic             use_rr
);

    always_comb begin
        use_rr = &valid_vec;
        victim = rr_ptr;
        if (!use_rr) begin
            // Descending scan so the last assignment is the lowest invalid index.
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (!valid_vec[i]) begin
                    victim = WAY_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - parametrised N-way set-associative read-only cache with handshaked line fill
// Optional hit/miss counters enabled by CACHE_STATS_EN.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int SETS       = 512,
    parameter int WAYS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [DATA_W-1:0]   resp_data,
    output logic [ADDR_W-$clog2(SETS)-$clog2(LINE_WORDS)-1:0] resp_tag,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rdata_valid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_hits,
    output logic [STAT_W-1:0]   stat_misses
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Data and tags carry no reset; the valid bits alone gate their meaning.
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAY_W-1:0]  rr_q     [SETS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_hit_q, resp_hit_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_w;
    logic              use_rr;
    logic              fill_we;
    logic              line_done;
    logic              rr_inc;

    assign off = OFF_W'(addr_offset(64'(addr_q), OFF_W));
    assign idx = IDX_W'(addr_index(64'(addr_q), OFF_W, IDX_W));
    assign tag = TAG_W'(addr_tag(64'(addr_q), OFF_W, IDX_W));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_vec (valid_q[idx]),
        .rr_ptr    (rr_q[idx]),
        .victim    (victim_w),
        .use_rr    (use_rr)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        victim_d       = victim_q;
        beat_d         = beat_q;
        resp_data_d    = resp_data_q;
        resp_hit_d     = resp_hit_q;
        resp_tag_d     = resp_tag_q;
        mem_req_addr_d = mem_req_addr_q;
        fill_we        = 1'b0;
        line_done      = 1'b0;
        rr_inc         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_tag_d = tag;
                if (hit) begin
                    resp_hit_d  = 1'b1;
                    resp_data_d = data_mem[idx][hit_way][off];
                    state_d     = RESPOND;
                end else begin
                    resp_hit_d     = 1'b0;
                    victim_d       = victim_w;
                    rr_inc         = use_rr;
                    mem_req_addr_d = {tag, idx, {OFF_W{1'b0}}};
                    state_d        = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rdata_valid) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == off) begin
                        resp_data_d = mem_rdata;
                    end
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        line_done = 1'b1;
                        state_d   = RESPOND;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            victim_q       <= '0;
            beat_q         <= '0;
            resp_data_q    <= '0;
            resp_hit_q     <= 1'b0;
            resp_tag_q     <= '0;
            mem_req_addr_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            victim_q       <= victim_d;
            beat_q         <= beat_d;
            resp_data_q    <= resp_data_d;
            resp_hit_q     <= resp_hit_d;
            resp_tag_q     <= resp_tag_d;
            mem_req_addr_q <= mem_req_addr_d;
            if (line_done) begin
                valid_q[idx][victim_q] <= 1'b1;
            end
            if (rr_inc) begin
                rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_mem[idx][victim_q][beat_q] <= mem_rdata;
        end
        if (line_done) begin
            tag_mem[idx][victim_q] <= tag;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESPOND);
    assign mem_req_valid = (state_q == MISS_REQ);
    assign resp_hit      = resp_hit_q;
    assign resp_data     = resp_data_q;
    assign resp_tag      = resp_tag_q;
    assign mem_req_addr  = mem_req_addr_q;

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] stat_hits_q, stat_hits_d;
    logic [STAT_W-1:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == LOOKUP) begin
            if (hit && (stat_hits_q != '1)) begin
                stat_hits_d = stat_hits_q + STAT_W'(1);
            end
            if (!hit && (stat_misses_q != '1)) begin
                stat_misses_d = stat_misses_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule
